// File: rtl/lab8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lab8_pkg
// Purpose  : Shared types and helpers for the lab8 input-conditioning blocks.
//            - btn_state_t  : button debounce / press-classification states
//            - ms_to_cycles : converts a millisecond interval to clock cycles
// Revision : 1.0  initial release
// ============================================================================
package lab8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_PRESSED     = 3'd2,
        ST_HELD        = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } btn_state_t;

    // Divide first so large clock rates do not overflow 32 bits.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage : lab8_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for a single asynchronous input.
// Ports    : clk   - destination clock, rising edge
//            rst_n - asynchronous active-low reset (flops load RESET_VAL)
//            d     - asynchronous input
//            q     - synchronised output, d delayed by two rising edges
// Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/dir_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dir_button_ctrl
// Purpose  : Conditions one raw push-button into counter controls.
//            A debounced short press toggles direction; a debounced hold
//            longer than HOLD_MS toggles run. Each press performs at most
//            one action. All outputs are registered.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-low reset
//            btn_in     - raw bouncy button, 1 = pressed
//            direction  - counter direction level
//            run        - 1 = counter enabled, 0 = paused
//            btn_level  - debounced button level
//            dir_pulse  - one-cycle strobe when direction toggles
//            hold_pulse - one-cycle strobe when run toggles
// Revision : 1.0  initial release
// ============================================================================
module dir_button_ctrl
    import lab8_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned HOLD_MS     = 800
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic direction,
    output logic run,
    output logic btn_level,
    output logic dir_pulse,
    output logic hold_pulse
);

    localparam int unsigned DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned HOLD_CYCLES = ms_to_cycles(CLK_HZ, HOLD_MS);
    localparam int unsigned CNT_W       = $clog2(HOLD_CYCLES);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic             btn_sync;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             short_press;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (btn_in),
        .q     (btn_sync)
    );

    // cnt is shared by every timed state and is cleared on each transition,
    // so each state times its own window from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            short_press <= 1'b0;
            direction   <= 1'b0;
            run         <= 1'b1;
            btn_level   <= 1'b0;
            dir_pulse   <= 1'b0;
            hold_pulse  <= 1'b0;
        end else begin
            dir_pulse  <= 1'b0;
            hold_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (btn_sync) begin
                        state <= ST_DEB_PRESS;
                        cnt   <= '0;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!btn_sync) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= ST_PRESSED;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // Release is tested first so a release coinciding with
                    // the hold terminal count is classified as short.
                    if (!btn_sync) begin
                        state       <= ST_DEB_RELEASE;
                        cnt         <= '0;
                        short_press <= 1'b1;
                    end else if (cnt == HOLD_LAST) begin
                        state      <= ST_HELD;
                        cnt        <= '0;
                        run        <= ~run;
                        hold_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!btn_sync) begin
                        state       <= ST_DEB_RELEASE;
                        cnt         <= '0;
                        short_press <= 1'b0;
                    end
                end
                ST_DEB_RELEASE: begin
                    // A bounce back to pressed restarts the release window
                    // rather than returning to a pressed state.
                    if (btn_sync) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                        if (short_press) begin
                            direction <= ~direction;
                            dir_pulse <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule : dir_button_ctrl
`default_nettype wire

// File: tb/tb_dir_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dir_button_ctrl
// Purpose  : Self-checking bench for dir_button_ctrl with DB_CYCLES=4 and
//            HOLD_CYCLES=20. A run-length model of the press rules is
//            compared against the DUT on every falling edge; directed
//            scenarios add literal latency and level expectations.
//            Latencies are counted with edge 0 being the first rising edge
//            that samples the new btn_in value.
// Revision : 1.0  initial release
// ============================================================================
module tb_dir_button_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 20;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic btn_in = 1'b0;
    logic direction, run, btn_level, dir_pulse, hold_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dir_button_ctrl #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .HOLD_MS     (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .direction  (direction),
        .run        (run),
        .btn_level  (btn_level),
        .dir_pulse  (dir_pulse),
        .hold_pulse (hold_pulse)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The button value seen by the decision logic is btn_in two samples ago.
    // A press is accepted after DB+1 consecutive pressed samples, a hold
    // after a further HOLD pressed samples, and a release after DB+1
    // consecutive released samples (a pressed sample restarts that window).
    bit m_dir, m_run, m_level, m_dp, m_hp, m_rel, m_held;
    bit h1, h2, x;
    int ones, zeros;

    task automatic model_reset();
        m_dir = 0; m_run = 1; m_level = 0; m_dp = 0; m_hp = 0;
        m_rel = 0; m_held = 0; h1 = 0; h2 = 0; ones = 0; zeros = 0;
    endtask

    task automatic model_step();
        x  = h2;
        h2 = h1;
        h1 = btn_in;
        m_dp = 0;
        m_hp = 0;
        if (!m_level) begin
            if (x) begin
                ones++;
                if (ones == DB + 1) begin
                    m_level = 1; m_held = 0; m_rel = 0;
                end
            end else begin
                ones = 0;
            end
        end else if (!m_rel) begin
            if (!x) begin
                m_rel = 1;
                zeros = 1;
            end else begin
                ones++;
                if (!m_held && ones == DB + 1 + HOLD) begin
                    m_held = 1; m_run = ~m_run; m_hp = 1;
                end
            end
        end else begin
            if (x) begin
                zeros = 1;
            end else begin
                zeros++;
                if (zeros == DB + 1) begin
                    m_level = 0; m_rel = 0; ones = 0;
                    if (!m_held) begin
                        m_dir = ~m_dir; m_dp = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else        model_step();
        end
    end

    // ---------------- continuous compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("cyc_direction",  direction,  m_dir);
            check("cyc_run",        run,        m_run);
            check("cyc_btn_level",  btn_level,  m_level);
            check("cyc_dir_pulse",  dir_pulse,  m_dp);
            check("cyc_hold_pulse", hold_pulse, m_hp);
        end
    end

    // Drive btn_in = level (inverted at index glitch_at) for 60 edges and
    // report the edge index of the first selected pulse and the pulse count.
    // Must be called just after a falling edge.
    task automatic watch(input int glitch_at, input bit level, input bit sel,
                         output int first_at, output int count);
        first_at = -1;
        count    = 0;
        for (int n = 0; n < 60; n++) begin
            btn_in = (n == glitch_at) ? ~level : level;
            @(posedge clk);
            #1;
            if ((sel ? hold_pulse : dir_pulse) === 1'b1) begin
                if (first_at < 0) first_at = n;
                count++;
            end
            @(negedge clk);
        end
    endtask

    task automatic hold_btn(input int cycles);
        btn_in = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    int at, cnt;

    initial begin
        // Reset with a toggling button
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            btn_in = ~btn_in;
        end
        @(negedge clk);
        btn_in = 1'b0;
        #1;
        check("rst_direction", direction, 0);
        check("rst_run",       run,       1);
        check("rst_level",     btn_level, 0);
        #1 reset = 1'b1;
        repeat (4) @(negedge clk);

        // Bounce rejection
        hold_btn(2);
        btn_in = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_level",     btn_level, 0);
        check("bounce_direction", direction, 0);

        // Short press
        hold_btn(10);
        check("short_level_high", btn_level, 1);
        watch(-1, 1'b0, 1'b0, at, cnt);
        check("short_latency",   at,        6);
        check("short_count",     cnt,       1);
        check("short_direction", direction, 1);
        check("short_run",       run,       1);

        // Long press, then release
        watch(-1, 1'b1, 1'b1, at, cnt);
        check("long_latency", at,  26);
        check("long_count",   cnt, 1);
        check("long_run",     run, 0);
        watch(-1, 1'b0, 1'b0, at, cnt);
        check("long_rel_dir_pulses", cnt,       0);
        check("long_rel_direction",  direction, 1);

        // Repeat long press returns run to 1
        watch(-1, 1'b1, 1'b1, at, cnt);
        check("long2_count", cnt, 1);
        check("long2_run",   run, 1);
        watch(-1, 1'b0, 1'b0, at, cnt);
        check("long2_rel_dir_pulses", cnt, 0);

        // Release glitch restarts the release window
        hold_btn(10);
        watch(2, 1'b0, 1'b0, at, cnt);
        check("glitch_latency",   at,        8);
        check("glitch_count",     cnt,       1);
        check("glitch_direction", direction, 0);

        // Short press to set direction=1, then reset mid-press
        hold_btn(10);
        watch(-1, 1'b0, 1'b0, at, cnt);
        check("pre_rst_direction", direction, 1);
        hold_btn(12);
        check("pre_rst_level", btn_level, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_direction", direction,  0);
        check("midrst_run",       run,        1);
        check("midrst_level",     btn_level,  0);
        check("midrst_dp",        dir_pulse,  0);
        check("midrst_hp",        hold_pulse, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;

        // Still-held button after reset is a fresh short press
        hold_btn(10);
        watch(-1, 1'b0, 1'b0, at, cnt);
        check("postrst_latency",   at,        6);
        check("postrst_count",     cnt,       1);
        check("postrst_direction", direction, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dir_button_ctrl
`default_nettype wire
